// File: rtl/viterbi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : viterbi_pkg                                               |
// | Purpose  : Shared constants, state type and symbol helpers for the   |
// |            rate 1/2, K=3 convolutional codec (generators 7, 5).      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package viterbi_pkg;

  localparam int          c_K          = 3;
  localparam int          c_NUM_STATES = 1 << (c_K - 1);
  localparam logic [2:0]  c_G7         = 3'o7;
  localparam logic [2:0]  c_G5         = 3'o5;

  // Trellis / encoder state {s1, s0}; s1 is the most recent previous bit.
  typedef logic [c_K-2:0] state_t;

  // Coded symbol {g7, g5} produced by bit b leaving state st.
  function automatic logic [1:0] expected_sym(input logic b, input state_t st);
    logic [2:0] v;
    v = {b, st};
    return {^(v & c_G7), ^(v & c_G5)};
  endfunction

  // Hamming distance between two 2-bit symbols (0..2).
  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    return {1'b0, a[1] ^ b[1]} + {1'b0, a[0] ^ b[0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : conv_encoder                                              |
// | Purpose  : Rate 1/2, K=3 convolutional encoder, one-cycle latency.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module conv_encoder
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enable,
  input  logic       i_d,
  output logic       o_valid,
  output logic [1:0] o_sym
);

  state_t r_state;

  // Encode one bit per enabled cycle; symbol and state hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      o_sym   <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= i_enable;
      if (i_enable) begin
        o_sym   <= expected_sym(i_d, r_state);
        r_state <= {i_d, r_state[1]};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/viterbi_codec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : viterbi_codec                                             |
// | Purpose  : K=3 convolutional encoder plus an independent 4-state     |
// |            hard-decision Viterbi decoder with register-exchange      |
// |            survivors and normalised saturating path metrics.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module viterbi_codec
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_in,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_out,
  input  logic       dec_enable,
  input  logic [1:0] dec_d_in,
  output logic       dec_d_out,
  output logic       dec_valid_o
);

  localparam int                  c_SUM_W    = PM_W + 2;
  localparam int                  c_CNT_W    = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0]     c_PM_MAX   = '1;
  localparam logic [c_SUM_W-1:0]  c_SUM_MAX  = {2'b00, c_PM_MAX};
  localparam logic [c_CNT_W-1:0]  c_CNT_FULL = c_CNT_W'(TB_DEPTH);
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(TB_DEPTH - 1);

  conv_encoder u_enc (
    .clk      (clk),
    .rst      (rst),
    .i_enable (enc_enable_i),
    .i_d      (enc_d_in),
    .o_valid  (enc_valid_o),
    .o_sym    (enc_d_out)
  );

  logic [PM_W-1:0]     r_pm   [c_NUM_STATES];
  logic [TB_DEPTH-1:0] r_path [c_NUM_STATES];
  logic [c_CNT_W-1:0]  r_cnt;

  state_t              w_cur      [c_NUM_STATES];
  state_t              w_pred_a   [c_NUM_STATES];
  state_t              w_pred_b   [c_NUM_STATES];
  logic [c_SUM_W-1:0]  w_cand_a   [c_NUM_STATES];
  logic [c_SUM_W-1:0]  w_cand_b   [c_NUM_STATES];
  logic                w_take_b   [c_NUM_STATES];
  logic [c_SUM_W-1:0]  w_acs      [c_NUM_STATES];
  logic [TB_DEPTH-1:0] w_new_path [c_NUM_STATES];
  logic [c_SUM_W-1:0]  w_norm     [c_NUM_STATES];
  logic [PM_W-1:0]     w_pm_next  [c_NUM_STATES];
  logic [c_SUM_W-1:0]  w_min;
  state_t              w_best;

  // Add-compare-select: state {b,x} is reached from {x,0} or {x,1}; ties keep {x,0}.
  always_comb begin
    for (int s = 0; s < c_NUM_STATES; s++) begin
      w_cur[s]      = state_t'(s);
      w_pred_a[s]   = {w_cur[s][0], 1'b0};
      w_pred_b[s]   = {w_cur[s][0], 1'b1};
      w_cand_a[s]   = {2'b00, r_pm[w_pred_a[s]]}
                    + c_SUM_W'(hamming2(dec_d_in, expected_sym(w_cur[s][1], w_pred_a[s])));
      w_cand_b[s]   = {2'b00, r_pm[w_pred_b[s]]}
                    + c_SUM_W'(hamming2(dec_d_in, expected_sym(w_cur[s][1], w_pred_b[s])));
      w_take_b[s]   = (w_cand_b[s] < w_cand_a[s]);
      w_acs[s]      = w_take_b[s] ? w_cand_b[s] : w_cand_a[s];
      w_new_path[s] = {r_path[w_take_b[s] ? w_pred_b[s] : w_pred_a[s]][TB_DEPTH-2:0],
                       w_cur[s][1]};
    end
  end

  // Smallest of the four freshly selected metrics.
  always_comb begin
    w_min = w_acs[0];
    for (int s = 1; s < c_NUM_STATES; s++) begin
      if (w_acs[s] < w_min) w_min = w_acs[s];
    end
  end

  // Normalise to the minimum, saturate, and pick the lowest-index zero-metric state.
  always_comb begin
    w_best = '0;
    for (int s = c_NUM_STATES - 1; s >= 0; s--) begin
      w_norm[s]    = w_acs[s] - w_min;
      w_pm_next[s] = (w_norm[s] > c_SUM_MAX) ? c_PM_MAX : w_norm[s][PM_W-1:0];
      if (w_pm_next[s] == '0) w_best = state_t'(s);
    end
  end

  // Decoder state update: only enabled symbols advance the trellis.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < c_NUM_STATES; s++) begin
        r_pm[s]   <= (s == 0) ? '0 : c_PM_MAX;
        r_path[s] <= '0;
      end
      r_cnt       <= '0;
      dec_d_out   <= 1'b0;
      dec_valid_o <= 1'b0;
    end else begin
      dec_valid_o <= 1'b0;
      if (dec_enable) begin
        for (int s = 0; s < c_NUM_STATES; s++) begin
          r_pm[s]   <= w_pm_next[s];
          r_path[s] <= w_new_path[s];
        end
        dec_d_out   <= w_new_path[w_best][TB_DEPTH-1];
        dec_valid_o <= (r_cnt >= c_CNT_LAST);
        if (r_cnt != c_CNT_FULL) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_viterbi_codec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_viterbi_codec                                          |
// | Purpose  : Self-checking bench for viterbi_codec: history-based      |
// |            reference model plus directed literal expectations.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_viterbi_codec;

  localparam int TBD = 16;
  localparam int NB  = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       enc_enable_i;
  logic       enc_d_in;
  logic       enc_valid_o;
  logic [1:0] enc_d_out;
  logic       dec_enable;
  logic [1:0] dec_d_in;
  logic       dec_d_out;
  logic       dec_valid_o;

  int checks = 0;
  int errors = 0;

  viterbi_codec #(.TB_DEPTH(TBD), .PM_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .enc_enable_i (enc_enable_i),
    .enc_d_in     (enc_d_in),
    .enc_valid_o  (enc_valid_o),
    .enc_d_out    (enc_d_out),
    .dec_enable   (dec_enable),
    .dec_d_in     (dec_d_in),
    .dec_d_out    (dec_d_out),
    .dec_valid_o  (dec_valid_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Info bits accepted by the encoder since the last reset, in order.
  logic       info_hist [$];
  int         dec_n;
  logic       exp_ev;
  logic [1:0] exp_eo;
  logic       exp_dv;
  logic       exp_do;

  function automatic logic prev_bit(input int back);
    int n;
    n = info_hist.size();
    return (n >= back) ? info_hist[n-back] : 1'b0;
  endfunction

  // Expected outputs follow from the code equations and the decoding latency:
  // the k-th decoded bit is the k-th encoded bit, emitted once TBD symbols are in.
  always @(posedge clk) begin
    if (rst) begin
      info_hist.delete();
      dec_n  <= 0;
      exp_ev <= 1'b0;
      exp_eo <= 2'b00;
      exp_dv <= 1'b0;
      exp_do <= 1'b0;
    end else begin
      exp_ev <= enc_enable_i;
      if (enc_enable_i) begin
        exp_eo <= {enc_d_in ^ prev_bit(1) ^ prev_bit(2), enc_d_in ^ prev_bit(2)};
        info_hist.push_back(enc_d_in);
      end
      exp_dv <= dec_enable && (dec_n + 1 >= TBD);
      if (dec_enable) begin
        dec_n  <= dec_n + 1;
        exp_do <= (dec_n + 1 >= TBD) ? info_hist[dec_n+1-TBD] : 1'b0;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("enc_valid_o", 32'(enc_valid_o), 32'(exp_ev));
    check("enc_d_out",   32'(enc_d_out),   32'(exp_eo));
    check("dec_valid_o", 32'(dec_valid_o), 32'(exp_dv));
    check("dec_d_out",   32'(dec_d_out),   32'(exp_do));
  end

  // ---------------- stimulus ----------------
  logic       data [NB];
  logic       got  [$];
  logic       ref_got [$];
  logic       pend_v;
  logic [1:0] pend_s;
  bit         zero_mode;
  logic       dec_en_seen;

  // One cycle: drive encoder, feed last cycle's encoder symbol to the decoder.
  task automatic step(input logic en, input logic d, input logic flip_b1);
    dec_enable   = pend_v;
    dec_d_in     = pend_s;
    dec_en_seen  = pend_v;
    enc_enable_i = en;
    enc_d_in     = d;
    @(posedge clk);
    #1;
    pend_v = enc_valid_o;
    pend_s = enc_d_out ^ {flip_b1, 1'b0};
    if (dec_valid_o) got.push_back(dec_d_out);
    if (zero_mode) begin
      check("zero_dec_d_out", 32'(dec_d_out), 32'd0);
      check("zero_pm0",       32'(dut.r_pm[0]), 32'd0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enc_enable_i = 1'b0; enc_d_in = 1'b0;
    dec_enable = 1'b0; dec_d_in = 2'b00; pend_v = 1'b0; pend_s = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_stream(input bit use_data, input bit flips, input bit stall);
    got.delete();
    for (int i = 0; i < NB + TBD + 4; i++) begin
      logic b;
      int   idle;
      b = (use_data && i < NB) ? data[i] : 1'b0;
      if (stall) begin
        idle = int'($urandom_range(0, 2));
        repeat (idle) step(1'b0, 1'b0, 1'b0);
      end
      step(1'b1, b, flips && (i % 8 == 7));
    end
  endtask

  task automatic check_decoded(input string name);
    int bad;
    bad = 0;
    check({name, "_count"}, 32'(got.size() >= NB), 32'd1);
    for (int i = 0; i < NB && i < got.size(); i++) begin
      if (got[i] !== data[i]) bad++;
    end
    check({name, "_mismatches"}, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [1:0] enc_lit [5];
    logic       enc_bits [5];
    int         nen;
    bit         seen;

    enc_lit  = '{2'b00, 2'b11, 2'b01, 2'b01, 2'b00};
    enc_bits = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    zero_mode = 1'b0;
    for (int i = 0; i < NB; i++) data[i] = 1'($urandom_range(0, 1));

    // Reset state.
    do_reset();
    check("rst_enc_valid", 32'(enc_valid_o), 32'd0);
    check("rst_enc_d_out", 32'(enc_d_out),   32'd0);
    check("rst_dec_valid", 32'(dec_valid_o), 32'd0);
    check("rst_dec_d_out", 32'(dec_d_out),   32'd0);
    check("rst_pm1",       32'(dut.r_pm[1]), 32'd63);

    // Encoder literal sequence 0,1,1,0,1 from state 00.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, enc_bits[i], 1'b0);
      check("enc_literal", 32'(enc_d_out), 32'(enc_lit[i]));
    end

    // Clean random stream.
    do_reset();
    run_stream(1'b1, 1'b0, 1'b0);
    check_decoded("clean");
    ref_got = got;

    // Same stream, bit[1] of every 8th symbol flipped.
    do_reset();
    run_stream(1'b1, 1'b1, 1'b0);
    check_decoded("flipped");

    // All-zero input.
    do_reset();
    zero_mode = 1'b1;
    run_stream(1'b0, 1'b0, 1'b0);
    zero_mode = 1'b0;

    // Random stalls must not change the decoded sequence.
    do_reset();
    run_stream(1'b1, 1'b0, 1'b1);
    check_decoded("stalled");
    begin
      int diff;
      diff = 0;
      for (int i = 0; i < NB && i < got.size() && i < ref_got.size(); i++)
        if (got[i] !== ref_got[i]) diff++;
      check("stall_vs_clean", 32'(diff), 32'd0);
    end

    // Mid-stream reset after 40 symbols.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, data[i], 1'b0);
    do_reset();
    check("midrst_dec_valid", 32'(dec_valid_o), 32'd0);
    nen  = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step(1'b1, data[(40 + i) % NB], 1'b0);
      if (dec_en_seen) nen++;
      if (dec_valid_o) seen = 1'b1;
    end
    check("midrst_valid_seen", 32'(seen), 32'd1);
    check("midrst_symbols",    32'(nen),  32'd16);
    for (int i = 0; i < 40; i++) step(1'b1, data[(140 + i) % NB], 1'b0);

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
